jesd_tx_scrambler: RTL and testbench

//  JESD204B TX-side 32-bit self-synchronous scrambler, polynomial 1 + x^14 + x^15.

---
 rtl/jesd204b_pkg.sv | 51 +++++
 rtl/jesd_skid_buffer.sv | 54 +++++
 rtl/jesd_tx_scrambler.sv | 73 +++++++
 tb/tb_jesd_tx_scrambler.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jesd204b_pkg.sv
// Shared JESD204B scrambler constants and word-level helpers, used by both the
// TX scrambler and the RX descrambler.
package jesd204b_pkg;

    localparam int LFSR_W = 15;
    localparam int TAP_A  = 14;
    localparam int TAP_B  = 15;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 15'h7fff;

    // Helpers work on a fixed wide container; callers pass their real width.
    localparam int MAX_DW = 256;

    typedef struct packed {
        logic [MAX_DW-1:0] s;
        logic [LFSR_W-1:0] next_state;
    } scr_result_t;

    // Octet 0 (bits [7:0]) lands in the top octet of a dw-bit word and vice versa.
    function automatic logic [MAX_DW-1:0] byte_rev(input logic [MAX_DW-1:0] word, input int dw);
        logic [MAX_DW-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_DW / 8; b++) begin
            if (b < dw / 8) r[8*(dw/8-1-b) +: 8] = word[8*b +: 8];
        end
        return r;
    endfunction

    // Unrolled self-synchronous scrambler: MSB is the earliest bit on the link,
    // st[LFSR_W-1] is the bit fifteen positions before it.
    function automatic scr_result_t scramble_word(input logic [LFSR_W-1:0] st,
                                                  input logic [MAX_DW-1:0] d,
                                                  input int dw);
        scr_result_t r;
        logic        e_a;
        logic        e_b;
        // NOTE: every result bit gets a default before the loop, so no latch can form.
        r   = '0;
        e_a = 1'b0;
        e_b = 1'b0;
        for (int i = MAX_DW - 1; i >= 0; i--) begin
            if (i < dw) begin
                e_b    = (i + TAP_B >= dw) ? st[i+TAP_B-dw] : r.s[i+TAP_B];
                e_a    = (i + TAP_A >= dw) ? st[i+TAP_A-dw] : r.s[i+TAP_A];
                r.s[i] = d[i] ^ e_b ^ e_a;
            end
        end
        r.next_state = r.s[LFSR_W-1:0];
        return r;
    endfunction

endpackage

// File: rtl/jesd_skid_buffer.sv
// Two-entry valid/ready register slice: output register plus one skid register.
// in_ready_o is purely registered, so out_ready_i never reaches it combinationally.
module jesd_skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             out_valid_q;
    logic             skid_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             in_fire;
    logic             out_free;

    assign in_ready_o  = ~skid_valid_q;
    assign in_fire     = in_valid_i & ~skid_valid_q;
    assign out_free    = ~out_valid_q | out_ready_i;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_data_q   <= '0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_data_q   <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q <= in_fire;
                if (in_fire) out_data_q <= in_data_i;
            end
        end else if (in_fire) begin
            skid_valid_q <= 1'b1;
        end
    end

    // NOTE: skid data needs no reset; skid_valid_q alone decides whether it is live.
    always_ff @(posedge clk_i) begin
        if (in_fire && !out_free) skid_data_q <= in_data_i;
    end

endmodule

// File: rtl/jesd_tx_scrambler.sv
// JESD204B TX lane scrambler (1 + x^14 + x^15) with valid/ready skid output stage.
// Optional JESD_TX_SCR_STATS_EN adds word_cnt_o counting scrambled words accepted.
module jesd_tx_scrambler
    import jesd204b_pkg::*;
#(
    parameter int                DATA_WIDTH = 32,
    parameter logic [LFSR_W-1:0] SEED       = DEFAULT_SEED
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  scramble_en_i,
    input  logic                  seed_load_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
`ifdef JESD_TX_SCR_STATS_EN
    ,
    output logic [31:0]           word_cnt_o
`endif
);

    logic [LFSR_W-1:0]     state_q;
    logic [LFSR_W-1:0]     st;
    logic [LFSR_W-1:0]     next_state;
    logic [MAX_DW-1:0]     d_wide;
    logic [MAX_DW-1:0]     s_wide;
    scr_result_t           scr;
    logic [DATA_WIDTH-1:0] scr_word;
    logic                  in_ready;
    logic                  in_fire;

    // A seed load coincident with a handshake scrambles that very word from SEED.
    assign st         = seed_load_i ? SEED : state_q;
    assign d_wide     = byte_rev(MAX_DW'(in_data_i), DATA_WIDTH);
    assign scr        = scramble_word(st, d_wide, DATA_WIDTH);
    assign s_wide     = scramble_en_i ? scr.s : d_wide;
    assign next_state = scramble_en_i ? scr.next_state : d_wide[LFSR_W-1:0];
    assign scr_word   = DATA_WIDTH'(byte_rev(s_wide, DATA_WIDTH));
    assign in_fire    = in_valid_i & in_ready;
    assign in_ready_o = in_ready;

    // Pass-through words still load the state, mirroring the RX side.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)          state_q <= SEED;
        else if (in_fire)     state_q <= next_state;
        else if (seed_load_i) state_q <= SEED;
    end

`ifdef JESD_TX_SCR_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        word_cnt_o <= '0;
        else if (seed_load_i)               word_cnt_o <= {31'd0, in_fire & scramble_en_i};
        else if (in_fire && scramble_en_i)  word_cnt_o <= word_cnt_o + 32'd1;
    end
`endif

    jesd_skid_buffer #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready),
        .in_data_i  (scr_word),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_data_o (out_data_o)
    );

endmodule

// File: tb/tb_jesd_tx_scrambler.sv
// Self-checking bench for jesd_tx_scrambler: serial bit-stream reference model,
// RX descrambler models for loopback/self-sync, scoreboard under backpressure.
module tb_jesd_tx_scrambler;

    localparam logic [14:0] SEED = 15'h7fff;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_data_i = '0;
    logic        scramble_en_i = 1'b0;
    logic        seed_load_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
`ifdef JESD_TX_SCR_STATS_EN
    logic [31:0] word_cnt_o;
`endif

    jesd_tx_scrambler dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .in_data_i    (in_data_i),
        .scramble_en_i(scramble_en_i),
        .seed_load_i  (seed_load_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .out_data_o   (out_data_o)
`ifdef JESD_TX_SCR_STATS_EN
        ,
        .word_cnt_o   (word_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: link bits go out octet 0 first, MSB first within each octet.
    // hist[0] is the most recent link bit, hist[14] the one fifteen bits back.
    logic [14:0] tx_hist;
    logic [31:0] exp_q[$];
    logic [31:0] plain_q[$];
    logic [31:0] cnt_m;

    task automatic tx_model(input logic [31:0] data, input logic en, output logic [31:0] s);
        logic bit_s;
        s = '0;
        for (int k = 0; k < 4; k++) begin
            for (int b = 7; b >= 0; b--) begin
                bit_s = en ? (data[8*k+b] ^ tx_hist[13] ^ tx_hist[14]) : data[8*k+b];
                tx_hist = {tx_hist[13:0], bit_s};
                s[8*k+b] = bit_s;
            end
        end
    endtask

    task automatic rx_model(input logic [14:0] h_in, input logic [31:0] w,
                            output logic [14:0] h_out, output logic [31:0] p);
        logic [14:0] h;
        h = h_in;
        p = '0;
        for (int k = 0; k < 4; k++) begin
            for (int b = 7; b >= 0; b--) begin
                p[8*k+b] = w[8*k+b] ^ h[13] ^ h[14];
                h = {h[13:0], w[8*k+b]};
            end
        end
        h_out = h;
    endtask

    logic [14:0] rx_a;
    logic [14:0] rx_b;
    logic        lb_on = 1'b0;
    int          lb_idx;
    int          mism_b;
    int          bad_idx_b;
    int          diff_cnt;
    int          accepted;

    // One clock: drive at posedge+1, sample at negedge, return at posedge+1.
    task automatic cycle(input logic v, input logic [31:0] data, input logic en,
                         input logic sl, input logic ordy);
        logic        inf;
        logic        outf;
        logic [31:0] w;
        logic [31:0] p;
        logic [31:0] ra;
        logic [31:0] rb;
        in_valid_i    = v;
        in_data_i     = data;
        scramble_en_i = en;
        seed_load_i   = sl;
        out_ready_i   = ordy;
        @(negedge clk_i);
        check("in_ready", {31'd0, in_ready_o}, {31'd0, exp_q.size() < 2});
        check("out_valid", {31'd0, out_valid_o}, {31'd0, exp_q.size() > 0});
        inf  = v && in_ready_o;
        outf = out_valid_o && ordy;
        if (outf && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("out_data", out_data_o, w);
            if (lb_on && plain_q.size() > 0) begin
                p = plain_q.pop_front();
                rx_model(rx_a, out_data_o, rx_a, ra);
                rx_model(rx_b, out_data_o, rx_b, rb);
                check("loopback", ra, p);
                if (rb !== p) begin
                    if (mism_b == 0) bad_idx_b = lb_idx;
                    mism_b++;
                end
                if (out_data_o !== p) diff_cnt++;
                lb_idx++;
            end
        end
        if (inf) begin
            if (sl) tx_hist = SEED;
            tx_model(data, en, w);
            exp_q.push_back(w);
            if (lb_on) plain_q.push_back(data);
            if (sl) cnt_m = {31'd0, en};
            else if (en) cnt_m = cnt_m + 32'd1;
            accepted++;
        end else if (sl) begin
            tx_hist = SEED;
            cnt_m   = '0;
        end
        @(posedge clk_i);
        #1;
`ifdef JESD_TX_SCR_STATS_EN
        check("word_cnt", word_cnt_o, cnt_m);
`endif
    endtask

    task automatic model_reset();
        exp_q.delete();
        plain_q.delete();
        tx_hist = SEED;
        cnt_m   = '0;
    endtask

    task automatic do_reset();
        in_valid_i  = 1'b0;
        seed_load_i = 1'b0;
        rst_ni      = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    typedef struct {
        logic [31:0] data;
        logic        en;
        logic        sl;
        logic [31:0] exp_out;
        logic [14:0] exp_state;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{32'h1c1c_1c1c, 1'b0, 1'b0, 32'h1c1c_1c1c, 15'h1c1c};
        tbl[1] = '{32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 15'h0000};
        tbl[2] = '{32'h0000_0000, 1'b1, 1'b1, 32'h0c00_0200, 15'h000c};
        tbl[3] = '{32'h1234_5678, 1'b0, 1'b1, 32'h1234_5678, 15'h3412};

        model_reset();
        accepted = 0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("rst_out_data", out_data_o, 32'd0);
        check("rst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("rst_state", {17'd0, dut.state_q}, {17'd0, SEED});
        rst_ni = 1'b1;

        // Table vectors: pass-through, scrambling from seed, seed load on pass-through.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, tbl[i].data, tbl[i].en, tbl[i].sl, 1'b1);
            check("tbl_valid", {31'd0, out_valid_o}, 32'd1);
            check("tbl_data", out_data_o, tbl[i].exp_out);
            check("tbl_state", {17'd0, dut.state_q}, {17'd0, tbl[i].exp_state});
        end
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Loopback through two RX models: matched seed and zero seed (self-sync).
        do_reset();
        rx_a = SEED;
        rx_b = 15'h0000;
        lb_idx = 0; mism_b = 0; bad_idx_b = -1; diff_cnt = 0;
        lb_on = 1'b1;
        for (int i = 0; i < 1000; i++) cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, $urandom, 1'b1, 1'b0, 1'b1);
        lb_on = 1'b0;
        check("lb_words", lb_idx, 1000);
        check("scrambled_differs", {31'd0, diff_cnt > 0}, 32'd1);
        check("selfsync_mismatches", mism_b, 1);
        check("selfsync_bad_index", bad_idx_b, 0);

        // Backpressure: 30% out_ready duty, random valid and mode, garbage while idle.
        accepted = 0;
        for (int c = 0; c < 5000 && accepted < 500; c++)
            cycle($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)), 1'b0,
                  $urandom_range(0, 9) < 3);
        check("bp_accepted", accepted, 500);
        repeat (4) cycle(1'b0, $urandom, 1'b0, 1'b0, 1'b1);
        check("bp_drained", exp_q.size(), 0);

        // Seed load with handshake on word 100, then alone on cycle 300.
        for (int c = 0; c < 320; c++) begin
            if (c < 200) cycle(1'b1, $urandom, 1'b1, c == 100, 1'b1);
            else         cycle(1'b0, $urandom, 1'b1, c == 300, 1'b1);
`ifdef JESD_TX_SCR_STATS_EN
            if (c == 100) check("cnt_after_load_hs", word_cnt_o, 32'd1);
            if (c == 300) check("cnt_after_lone_load", word_cnt_o, 32'd0);
`endif
            if (c == 300) check("state_after_lone_load", {17'd0, dut.state_q}, {17'd0, SEED});
        end
        for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        // Reset mid-stream with output register and skid both full.
        cycle(1'b1, 32'hdead_beef, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'hcafe_f00d, 1'b1, 1'b0, 1'b0);
        check("skid_full_ready", {31'd0, in_ready_o}, 32'd0);
        check("skid_full_valid", {31'd0, out_valid_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid_o}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready_o}, 32'd1);
        check("midrst_out_data", out_data_o, 32'd0);
        model_reset();
        in_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cycle(1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        check("post_rst_word", out_data_o, 32'h0c00_0200);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
